// File: rtl/ysyx_22040386_mdu_pkg.sv
// Shared definitions for the RV64M multiply/divide sequencer: funct3 codes,
// FSM state encoding and default widths.
package ysyx_22040386_mdu_pkg;

  localparam int unsigned MDU_XLEN  = 64;
  localparam int unsigned MDU_CNT_W = 7;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // rs1 is treated as signed for mul, mulh, mulhsu, div, rem
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is treated as signed for mul, mulh, div, rem
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/ysyx_22040386_mdu_iter.sv
// One radix-2 step on the {hi, lo} accumulator: shift-add for multiply,
// restoring shift-subtract for divide (hi = partial remainder, lo = quotient).
module ysyx_22040386_mdu_iter
  import ysyx_22040386_mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic                i_is_div,
  input  logic [2*XLEN-1:0]   i_acc,
  input  logic [XLEN-1:0]     i_opnd,
  output logic [2*XLEN-1:0]   o_acc_c
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_trial;

  // Multiply adds the multiplicand on lo[0] then shifts right; divide shifts
  // left and keeps the trial difference when it does not borrow.
  always_comb begin
    w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
    w_trial  = w_rem_sh - {1'b0, i_opnd};
    if (!i_is_div) begin
      o_acc_c = {w_sum, i_acc[XLEN-1:1]};
    end else if (!w_trial[XLEN]) begin
      o_acc_c = {w_trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
    end else begin
      o_acc_c = {i_acc[2*XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ysyx_22040386_mdu_seq.sv
// Multi-cycle RV64M mul/div/rem sequencer with valid/ready on both sides.
// Optional MDU_EARLY_OUT_EN: trivial multiplies (zero operand) and divides
// with |a| < |b| complete in one cycle instead of running all iterations.
module ysyx_22040386_mdu_seq
  import ysyx_22040386_mdu_pkg::*;
#(
  parameter int unsigned XLEN  = MDU_XLEN,
  parameter int unsigned CNT_W = MDU_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2*XLEN-1:0] r_acc, w_acc_nxt;
  logic [XLEN-1:0]   r_opnd, w_opnd_nxt;
  logic [2:0]        r_op, w_op_nxt;
  logic              r_neg_q, w_neg_q_nxt;
  logic              r_neg_r, w_neg_r_nxt;
  logic [XLEN-1:0]   r_result, w_result_nxt;
  logic              r_in_ready, w_in_ready_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_busy, w_busy_nxt;

  logic              w_sa, w_sb;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_div0, w_ovf, w_early, w_spec;
  logic [XLEN-1:0]   w_early_res, w_spec_res;
  logic [2*XLEN-1:0] w_step, w_prod_fix;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

  ysyx_22040386_mdu_iter #(.XLEN(XLEN)) u_iter (
    .i_is_div (r_op[2]),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc_c  (w_step)
  );

  // Request decode: operand magnitudes and single-cycle special cases
  always_comb begin
    w_sa    = op_a_signed(in_op) & in_a[XLEN-1];
    w_sb    = op_b_signed(in_op) & in_b[XLEN-1];
    w_mag_a = w_sa ? -in_a : in_a;
    w_mag_b = w_sb ? -in_b : in_b;
    w_div0  = in_op[2] && (in_b == '0);
    w_ovf   = ((in_op == MDU_DIV) || (in_op == MDU_REM)) &&
              (in_a == SIGNED_MIN) && (in_b == '1);
`ifdef MDU_EARLY_OUT_EN
    w_early     = (!in_op[2] && ((in_a == '0) || (in_b == '0))) ||
                  (in_op[2] && (w_mag_a < w_mag_b));
    w_early_res = (in_op[2] && in_op[1]) ? in_a : '0;
`else
    w_early     = 1'b0;
    w_early_res = '0;
`endif
    w_spec = w_div0 | w_ovf | w_early;
    if (w_div0) begin
      w_spec_res = in_op[1] ? in_a : '1;
    end else if (w_ovf) begin
      w_spec_res = in_op[1] ? '0 : in_a;
    end else begin
      w_spec_res = w_early_res;
    end
  end

  // Sign fix-up of the last iteration's accumulator into the final result
  always_comb begin
    w_prod_fix = r_neg_q ? -w_step : w_step;
    w_quo      = w_step[XLEN-1:0];
    w_rem      = w_step[2*XLEN-1:XLEN];
    case (r_op)
      MDU_MUL:                        w_fix_res = w_prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              w_fix_res = r_neg_q ? -w_quo : w_quo;
      default:                        w_fix_res = r_neg_r ? -w_rem : w_rem;
    endcase
  end

  // Next-state and next-output logic; flush overrides everything
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_opnd_nxt   = r_opnd;
    w_op_nxt     = r_op;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        if (in_valid && !flush) begin
          w_op_nxt    = in_op;
          w_neg_q_nxt = w_sa ^ w_sb;
          w_neg_r_nxt = w_sa;
          if (w_spec) begin
            w_result_nxt = w_spec_res;
            w_state_nxt  = S_DONE;
          end else begin
            w_state_nxt = S_CALC;
            w_cnt_nxt   = '0;
            if (in_op[2]) begin
              w_acc_nxt  = {{XLEN{1'b0}}, w_mag_a};
              w_opnd_nxt = w_mag_b;
            end else begin
              w_acc_nxt  = {{XLEN{1'b0}}, w_mag_b};
              w_opnd_nxt = w_mag_a;
            end
          end
        end
      end
      S_CALC: begin
        w_acc_nxt = w_step;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == LAST_ITER) begin
          w_result_nxt = w_fix_res;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_op        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_opnd      <= w_opnd_nxt;
      r_op        <= w_op_nxt;
      r_neg_q     <= w_neg_q_nxt;
      r_neg_r     <= w_neg_r_nxt;
      r_result    <= w_result_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign busy       = r_busy;

endmodule

// File: tb/tb_ysyx_22040386_mdu_seq.sv
// Self-checking bench for ysyx_22040386_mdu_seq: scoreboard of expected
// results from a behavioural 128-bit arithmetic model.
module tb_ysyx_22040386_mdu_seq;
  import ysyx_22040386_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [63:0] in_a = 64'd0;
  logic [63:0] in_b = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  ysyx_22040386_mdu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural RV64M reference
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    ea = (op == MDU_MULHU) ? {64'd0, a} : {{64{a[63]}}, a};
    eb = (op == MDU_MULHU || op == MDU_MULHSU) ? {64'd0, b} : {{64{b[63]}}, b};
    p  = ea * eb;
    case (op)
      MDU_MUL: return p[63:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: return p[127:64];
      MDU_DIV: begin
        if (b == 64'd0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        return 64'(sa / sb);
      end
      MDU_DIVU: begin
        if (b == 64'd0) return '1;
        return a / b;
      end
      MDU_REM: begin
        if (b == 64'd0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
        return 64'(sa % sb);
      end
      default: begin
        if (b == 64'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Issue one request and wait (bounded) for out_valid; lat counts the
  // accepting edge as 1. Inputs are scrambled right after acceptance.
  task automatic drive_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat, output bit busy_ok);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    in_op = 3'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    res = out_result;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_result=%h, required 1 0 0 0",
               in_ready, out_valid, busy, out_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [63:0] res, exp;
    int lat;
    bit bok;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    drive_op(MDU_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, res, lat, bok);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL mul_7x-3: got %h required %h", res, exp); end
    checks++;
    if (lat != 65) begin errors++; $display("FAIL mul_latency: got %0d required 65", lat); end
    checks++;
    if (!bok) begin errors++; $display("FAIL mul_busy: busy dropped during operation, required high"); end

    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    drive_op(MDU_MULHU, '1, '1, res, lat, bok);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL mulhu_max: got %h required %h", res, exp); end

    exp_q.push_back(64'd0);
    drive_op(MDU_MULH, '1, '1, res, lat, bok);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL mulh_m1xm1: got %h required %h", res, exp); end
  endtask

  task automatic test_div();
    logic [2:0]  ops[4] = '{MDU_DIV, MDU_REM, MDU_DIVU, MDU_REMU};
    logic [63:0] as[4]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100};
    logic [63:0] bs[4]  = '{64'd2, 64'd2, 64'd7, 64'd7};
    logic [63:0] ex[4]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd14, 64'd2};
    logic [63:0] res, exp;
    int lat;
    bit bok;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex[i]);
      drive_op(ops[i], as[i], bs[i], res, lat, bok);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL div_case%0d op=%0d: got %h required %h", i, ops[i], res, exp);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops[4] = '{MDU_DIV, MDU_REM, MDU_DIV, MDU_REM};
    logic [63:0] as[4]  = '{64'd5, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    logic [63:0] bs[4]  = '{64'd0, 64'd0, '1, '1};
    logic [63:0] ex[4]  = '{'1, 64'd5, 64'h8000_0000_0000_0000, 64'd0};
    logic [63:0] res, exp;
    int lat;
    bit bok;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex[i]);
      drive_op(ops[i], as[i], bs[i], res, lat, bok);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL special%0d result: got %h required %h", i, res, exp);
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL special%0d latency: got %0d required 1", i, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, res, exp;
    logic [2:0]  op;
    int lat;
    bit bok;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      if (i % 4 == 1) a = -a;
      exp_q.push_back(model(op, a, b));
      drive_op(op, a, b, res, lat, bok);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp || lat >= 200) begin
        errors++;
        $display("FAIL random%0d op=%0d a=%h b=%h: got %h (lat %0d) required %h", i, op, a, b, res, lat, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[3] = '{MDU_MULHSU, MDU_DIVU, MDU_REM};
    logic [63:0] as[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd17};
    logic [63:0] bs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFB};
    logic [63:0] res, exp;
    int lat;
    bit bok;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(ops[i], as[i], bs[i]));
    for (int i = 0; i < 3; i++) begin
      drive_op(ops[i], as[i], bs[i], res, lat, bok);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL b2b%0d: got %h required %h", i, res, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] res, exp;
    int lat;
    bit bok;
    out_ready = 1'b0;
    exp_q.push_back(64'd14);
    drive_op(MDU_DIVU, 64'd100, 64'd7, res, lat, bok);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL bp_result: got %h required %h", res, exp); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== exp || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b out_result=%h in_ready=%b busy=%b required 1 %h 0 1",
                 i, out_valid, out_result, in_ready, busy, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_flush();
    logic [63:0] res, exp;
    int lat;
    bit bok;
    bit seen;
    @(negedge clk);
    in_op = MDU_MUL; in_a = 64'd123; in_b = 64'd456; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc: in_ready=%b busy=%b out_valid=%b required 1 0 0", in_ready, busy, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_no_result: out_valid seen=1 required 0"); end

    // flush beats a simultaneous request in IDLE
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = MDU_DIVU; in_a = 64'd9; in_b = 64'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_req: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end

    exp_q.push_back(64'd56088);
    drive_op(MDU_MUL, 64'd123, 64'd456, res, lat, bok);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL flush_next_req: got %h required %h", res, exp); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res, exp;
    int lat;
    bit bok;
    @(negedge clk);
    in_op = MDU_DIV; in_a = 64'd1000; in_b = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b out_result=%h required 1 0 0 0",
               in_ready, out_valid, busy, out_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
    exp_q.push_back(64'd142);
    drive_op(MDU_DIV, 64'd1000, 64'd7, res, lat, bok);
    exp = exp_q.pop_front();
    checks++;
    if (res !== exp) begin errors++; $display("FAIL reset_next_req: got %h required %h", res, exp); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_22040386_mdu_seq.md
Name: ysyx_22040386_mdu_seq

Overview:
Multi-cycle sequencer for the RV64M multiply/divide class, issued when the ALU decode selects a mul/div/rem operation. It accepts one operation through a valid/ready handshake, runs a radix-2 shift-add multiplier or restoring divider for XLEN iterations, and returns the result through a valid/ready handshake. While it is working it drives busy so the pipeline can stall.

Parameters:
XLEN, 64, operand and result width.
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset; asynchronous assertion, active-low.
flush  in  1  abort the current operation and discard any pending result.
in_valid  in  1  request valid.
in_ready  out  1  high only in IDLE.
in_op  in  3  RISC-V M funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
in_a  in  XLEN  rs1 operand.
in_b  in  XLEN  rs2 operand.
out_valid  out  1  result valid; high only in DONE.
out_ready  in  1  consumer accepts the result.
out_result  out  XLEN  result; stable while out_valid=1.
busy  out  1  high in CALC, and in DONE until the result is accepted.

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, out_result=0, counter=0, all internal registers 0.
- States and transitions:
  - IDLE: on in_valid & in_ready, latch op and operands, then go to CALC. A special case (see below) goes directly to DONE.
  - CALC: one iteration per cycle, counter runs 0..XLEN-1. After iteration XLEN-1, apply sign fix-up and register the result, then go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE. A new request cannot be accepted in the same cycle, because in_ready=0 in DONE.
- Latency: normal operation gives out_valid high XLEN+1 cycles after the accepting edge. A special case gives out_valid high 1 cycle after it.
- Signedness and magnitudes:
  - Signed operands are converted to magnitudes on accept.
  - Signed operands are in_a for mul, mulh, mulhsu, div and rem, and in_b for mul, mulh, div and rem.
  - Result negation is applied in the final CALC cycle.
- Multiply:
  - 2*XLEN accumulator; each iteration conditionally adds the multiplicand and shifts.
  - mul returns the low XLEN bits. mulh, mulhsu and mulhu return the high XLEN bits of the correctly signed 2*XLEN product.
- Divide:
  - Restoring algorithm, one quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Special cases (latency 1):
  - Divide by zero (in_b=0): div/divu give all-ones; rem/remu give in_a.
  - Signed overflow (in_a = -2^(XLEN-1), in_b = -1): div gives in_a; rem gives 0.
- flush:
  - Any state goes to IDLE on the next edge. out_valid drops and the result is lost.
  - flush has priority over in_valid and out_ready in the same cycle.
  - flush in IDLE together with in_valid: the request is not accepted.
- Inputs are sampled only at the accepting edge; later changes to in_a, in_b or in_op have no effect.
- Reset asserted mid-operation returns to reset values immediately, without waiting for clk.

Optional Feature:
MDU_EARLY_OUT_EN.
- Defined:
  - Multiply with either operand 0 gives result 0 with latency 1.
  - Divide with |a| < |b| (unsigned magnitudes) gives quotient 0 and remainder in_a with latency 1.
- Undefined: these cases take the full XLEN+1 latency; results are identical either way.

Decomposition:
- Shared package ysyx_22040386_mdu_pkg holds:
  - in_op funct3 localparams: MDU_MUL … MDU_REMU.
  - State encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - XLEN default.
- One sub-module: ysyx_22040386_mdu_iter, the per-cycle shift-add / shift-subtract step on accumulator and quotient registers, selected by an is_div input.
- The FSM, handshakes, sign handling and special cases stay in the top module.

Test Plan:
- mul 7 × -3 (in_op=000, in_a=7, in_b=0xFFFF_FFFF_FFFF_FFFD) -> out_result=0xFFFF_FFFF_FFFF_FFEB; out_valid first high 65 cycles after accept; busy high throughout.
- mulhu 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; mulh -1 × -1 -> 0.
- div -7 / 2 -> 0xFFFF_FFFF_FFFF_FFFD; rem -7 % 2 -> 0xFFFF_FFFF_FFFF_FFFF; divu 100/7 -> 14; remu 100 % 7 -> 2.
- div by zero: div 5/0 -> all-ones and rem 5%0 -> 5, each 1 cycle after accept. div 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; rem of the same operands -> 0.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles: out_valid and out_result stay stable, in_ready=0.
  - Assert flush at CALC iteration 30: IDLE next cycle, no out_valid. The next request completes correctly.
- Reset mid-CALC: pulse rst_n low asynchronously. All outputs return to reset values before the next edge; in_ready=1 after release.
